// File: rtl/e1_rx_clock_recovery.sv
// E1 receive bit-clock recovery: deglitches the hi/lo pulse lines, tracks pulse edges with
// a phase counter, emits one symbol per recovered bit and reports lock / loss of signal.
module e1_rx_clock_recovery #(
  parameter int PERIOD   = 15,
  parameter int LOCK_MAX = 15,
  parameter int LOS_BITS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_hi,
  input  logic in_lo,
  output logic out_hi,
  output logic out_lo,
  output logic out_stb,
  output logic lock
);

  localparam logic [4:0] P_LAST = 5'(PERIOD - 1);
  localparam logic [4:0] HALF_V = 5'((PERIOD - 1) / 2);
  localparam logic [5:0] P_W6   = 6'(PERIOD);
  localparam logic [3:0] LMAX_V = 4'(LOCK_MAX);
  localparam logic [7:0] LOS_V  = 8'(LOS_BITS);

  logic [2:0] hist_hi_q, hist_lo_q;
  logic       f_hi_q, f_lo_q, prev_any_q;
  logic [4:0] phase_q, phase_d;
  logic       s_hi_q, s_hi_d, s_lo_q, s_lo_d;
  logic       out_hi_q, out_hi_d, out_lo_q, out_lo_d, out_stb_q, out_stb_d;
  logic [3:0] lcnt_q, lcnt_d;
  logic       lock_q, lock_d;
  logic [7:0] los_q, los_d;

  logic       edge_c, wrap, good_edge, emit_hi, emit_lo;
  logic [5:0] phase_p2;

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction

  always_comb begin
    edge_c    = (f_hi_q | f_lo_q) & ~prev_any_q;
    phase_p2  = 6'(phase_q) + 6'd2;
    phase_d   = (phase_q == P_LAST) ? 5'd0 : phase_q + 5'd1;
    good_edge = edge_c & ((phase_q == 5'd0) | (phase_q == 5'd1) | (phase_q == P_LAST));
    if (edge_c) begin
      if (phase_q == 5'd0) begin
        phase_d = 5'd1;
      end else if (phase_q <= HALF_V) begin
        phase_d = phase_q;
      end else begin
        phase_d = (phase_p2 >= P_W6) ? 5'(phase_p2 - P_W6) : phase_p2[4:0];
      end
    end
    wrap    = phase_d < phase_q;
    emit_hi = s_hi_q | f_hi_q;
    emit_lo = s_lo_q | f_lo_q;

    s_hi_d    = wrap ? 1'b0 : emit_hi;
    s_lo_d    = wrap ? 1'b0 : emit_lo;
    out_hi_d  = wrap ? emit_hi : out_hi_q;
    out_lo_d  = wrap ? emit_lo : out_lo_q;
    out_stb_d = wrap;

    lcnt_d = lcnt_q;
    if (good_edge) begin
      lcnt_d = (lcnt_q == LMAX_V) ? lcnt_q : lcnt_q + 4'd1;
    end else if (edge_c) begin
      lcnt_d = (lcnt_q < 4'd4) ? 4'd0 : lcnt_q - 4'd4;
    end
    lock_d = lock_q;
    if (lcnt_d == LMAX_V) begin
      lock_d = 1'b1;
    end else if (lcnt_d == 4'd0) begin
      lock_d = 1'b0;
    end

    // Loss of signal overrides any edge-driven lock update in the same cycle.
    los_d = los_q;
    if (wrap) begin
      if (!emit_hi && !emit_lo) begin
        los_d = (los_q == LOS_V) ? los_q : los_q + 8'd1;
        if (los_d == LOS_V) begin
          lcnt_d = 4'd0;
          lock_d = 1'b0;
        end
      end else begin
        los_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_hi_q  <= '0;
      hist_lo_q  <= '0;
      f_hi_q     <= 1'b0;
      f_lo_q     <= 1'b0;
      prev_any_q <= 1'b0;
      phase_q    <= '0;
      s_hi_q     <= 1'b0;
      s_lo_q     <= 1'b0;
      out_hi_q   <= 1'b0;
      out_lo_q   <= 1'b0;
      out_stb_q  <= 1'b0;
      lcnt_q     <= '0;
      lock_q     <= 1'b0;
      los_q      <= '0;
    end else begin
      hist_hi_q  <= {hist_hi_q[1:0], in_hi};
      hist_lo_q  <= {hist_lo_q[1:0], in_lo};
      f_hi_q     <= maj3(hist_hi_q);
      f_lo_q     <= maj3(hist_lo_q);
      prev_any_q <= f_hi_q | f_lo_q;
      phase_q    <= phase_d;
      s_hi_q     <= s_hi_d;
      s_lo_q     <= s_lo_d;
      out_hi_q   <= out_hi_d;
      out_lo_q   <= out_lo_d;
      out_stb_q  <= out_stb_d;
      lcnt_q     <= lcnt_d;
      lock_q     <= lock_d;
      los_q      <= los_d;
    end
  end

  assign out_hi  = out_hi_q;
  assign out_lo  = out_lo_q;
  assign out_stb = out_stb_q;
  assign lock    = lock_q;

endmodule

// File: doc/e1_rx_clock_recovery.md
Name: e1_rx_clock_recovery

Overview:
- Consumes the registered E1 line samples (rx_hi, rx_lo) from the RX IOB stage and recovers the 2.048 Mbit/s bit clock from an oversampling system clock (nominal 15x, 30.72 MHz).
- Deglitches both lines, tracks pulse edges with a phase counter, and emits one symbol (hi/lo/space) per recovered bit with a strobe.
- Feeds the HDB3 decoder and provides a lock / loss-of-signal indication.

Parameters:
- PERIOD, 15, nominal clk cycles per E1 bit; legal range 8..31; phase counter is 5 bits.
- LOCK_MAX, 15, lock-counter saturation value; lock asserts at this value; legal range 4..15; counter is 4 bits.
- LOS_BITS, 32, consecutive pulse-free bit periods that force loss of lock; legal range 1..255.

Ports:
- clk  in  1  system clock, 30.72 MHz nominal
- rst_n  in  1  asynchronous active-low reset
- in_hi  in  1  positive-pulse sample from the RX IOB stage
- in_lo  in  1  negative-pulse sample from the RX IOB stage
- out_hi  out  1  recovered bit contained a positive pulse; valid when out_stb=1
- out_lo  out  1  recovered bit contained a negative pulse; valid when out_stb=1
- out_stb  out  1  one-cycle strobe, one per recovered bit
- lock  out  1  bit clock locked

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). While rst_n=0: out_hi, out_lo, out_stb and lock are 0; phase, sticky flags, filter history, lock counter and LOS counter are 0.
- Deglitch, per line: 3-bit shift history h. Filtered value f is registered 2-of-3 majority of h.
  - A clean step on in_* appears on f exactly 3 cycles later.
  - A 1-cycle glitch never reaches f.
- Edge: edge = (f_hi | f_lo) & ~prev_any, where prev_any is the registered (f_hi | f_lo).
- Phase counter p, 0..PERIOD-1, HALF = (PERIOD-1)/2. Next-value rules:
  - No edge: p+1 mod PERIOD.
  - Edge at p=0: p+1.
  - Edge at p in 1..HALF (line late): hold p.
  - Edge at p in HALF+1..PERIOD-1 (line early): p+2 mod PERIOD.
  - Correction is at most one cycle per edge.
- Wrap cycle: any cycle where next p < current p.
- Symbol accumulation:
  - Sticky flags: s_hi |= f_hi and s_lo |= f_lo every non-wrap cycle.
  - On a wrap cycle, registered outputs are out_hi = s_hi|f_hi, out_lo = s_lo|f_lo, out_stb = 1, and both sticky flags clear.
  - out_stb is 0 on all other cycles.
  - Latency from the first pulse sample on in_* to the strobe of its bit is 3 + (PERIOD-p_edge) cycles.
- Simultaneous hi and lo within one bit: both outputs are 1. No suppression here; the decoder flags the code violation.
- Lock counter:
  - Good edge (p in {0, 1, PERIOD-1}): +1, saturating at LOCK_MAX.
  - Bad edge (any other p): -4, saturating at 0.
  - lock sets when the counter reaches LOCK_MAX and clears when it reaches 0 (hysteresis).
- LOS counter:
  - On a wrap, increments when out_hi=out_lo=0 is emitted, saturating at LOS_BITS; clears when a pulse is emitted.
  - On reaching LOS_BITS: lock=0 and lock counter=0 in the same cycle.
  - A simultaneous good edge in that cycle is ignored.
- Free-run: with no input the phase keeps free-running and strobes continue with zero symbols.
- Mid-operation reset: async reset takes effect immediately. After release, the first strobe occurs PERIOD cycles later.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with toggling inputs -> all outputs 0. Release -> first out_stb at cycle PERIOD, with hi=lo=0.
- Ideal AMI stream: in_hi and in_lo alternate, each pulse high 7 cycles, period 15 -> one out_stb per 15 cycles, out_hi/out_lo alternate, lock=1 after the 15th good edge, no bad edges.
- Glitch rejection: 1-cycle in_hi pulses in every space bit of an all-zeros stream -> no edge, out_hi=out_lo=0 on every strobe.
- Frequency offset: pulse period 16, then 14, each for 200 bits -> strobe count equals pulse count in both cases (holds at p=1, advances at p=14), lock stays 1.
- LOS: after lock, stop all pulses -> lock falls on the 32nd consecutive empty strobe. Resume pulses -> lock returns after 15 good edges.
- Async reset mid-stream: pull rst_n low between strobes -> out_stb, out_hi, out_lo and lock go 0 without waiting for a clk edge.
